// File: rtl/maze_pkg.sv
// Shared maze geometry and colour palette for the maze pixel fetch datapath.
package maze_pkg;

  localparam int MAZE_W   = 224;
  localparam int MAZE_H   = 248;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;

  typedef logic [23:0] palette_t [32];

  localparam palette_t PALETTE = '{
    0:       24'h000000,
    1:       24'h2121DE,
    2:       24'hFFB8AE,
    3:       24'hFFB8AE,
    4:       24'hFFB8FF,
    default: 24'h000000
  };

endpackage

// File: rtl/maze_palette.sv
// Combinational tile-index to RGB lookup; the caller registers the result.
module maze_palette
  import maze_pkg::*;
(
  input  logic [4:0]  idx,
  output logic [23:0] rgb
);

  assign rgb = PALETTE[idx];

endmodule

// File: rtl/maze_pixel_fetch.sv
// Maps the VGA scan position onto the maze frame RAM and turns the returned
// tile index into a colour, keeping syncs aligned through a 3-register pipe.
module maze_pixel_fetch
  import maze_pkg::*;
#(
  parameter int MAZE_X0 = 208,
  parameter int MAZE_Y0 = 116
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              blank_n_in,
  output logic [ADDR_W-1:0] read_address,
  input  logic [4:0]        maze_data,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              frame_tick
);

  localparam logic [10:0] X_LO = 11'(MAZE_X0);
  localparam logic [10:0] X_HI = 11'(MAZE_X0 + MAZE_W);
  localparam logic [10:0] Y_LO = 11'(MAZE_Y0);
  localparam logic [10:0] Y_HI = 11'(MAZE_Y0 + MAZE_H);

  // y*224 as shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] y);
    logic [ADDR_W-1:0] ye;
    ye = {{(ADDR_W-8){1'b0}}, y};
    return (ye << 7) + (ye << 6) + (ye << 5);
  endfunction

  logic [10:0]       x_ext, y_ext;
  logic [7:0]        x_off, y_off;
  logic              in_region;
  logic [ADDR_W-1:0] addr_nxt;
  logic              frame_match;
  logic              match_prev;
  logic [23:0]       pal_rgb;

  logic              vld_p0, hs_p0, vs_p0, blank_p0;
  logic              vld_p1, hs_p1, vs_p1, blank_p1;
  logic [23:0]       rgb_p2;
  logic              hs_p2, vs_p2, blank_p2;

  assign x_ext = {1'b0, DrawX};
  assign y_ext = {1'b0, DrawY};

  // The range compare guards the subtraction, so offsets never wrap when used
  assign in_region = (x_ext >= X_LO) && (x_ext < X_HI) &&
                     (y_ext >= Y_LO) && (y_ext < Y_HI) &&
                     (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));

  assign x_off       = 8'(x_ext - X_LO);
  assign y_off       = 8'(y_ext - Y_LO);
  assign addr_nxt    = row_base(y_off) + {{(ADDR_W-8){1'b0}}, x_off};
  assign frame_match = (DrawX == 10'd0) && (DrawY == 10'd0);

  maze_palette u_palette (
    .idx (maze_data),
    .rgb (pal_rgb)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      vld_p0       <= 1'b0;
      hs_p0        <= 1'b1;
      vs_p0        <= 1'b1;
      blank_p0     <= 1'b0;
      vld_p1       <= 1'b0;
      hs_p1        <= 1'b1;
      vs_p1        <= 1'b1;
      blank_p1     <= 1'b0;
      rgb_p2       <= '0;
      hs_p2        <= 1'b1;
      vs_p2        <= 1'b1;
      blank_p2     <= 1'b0;
      match_prev   <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      // stage 1: RAM address, region flag, syncs
      read_address <= (in_region && blank_n_in) ? addr_nxt : '0;
      vld_p0       <= in_region;
      hs_p0        <= hs_in;
      vs_p0        <= vs_in;
      blank_p0     <= blank_n_in;
      // stage 2: RAM registers its output; flags follow
      vld_p1       <= vld_p0;
      hs_p1        <= hs_p0;
      vs_p1        <= vs_p0;
      blank_p1     <= blank_p0;
      // stage 3: colour and syncs presented together
      rgb_p2       <= (vld_p1 && blank_p1) ? pal_rgb : 24'h000000;
      hs_p2        <= hs_p1;
      vs_p2        <= vs_p1;
      blank_p2     <= blank_p1;
      match_prev   <= frame_match;
      frame_tick   <= frame_match && !match_prev;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_p2;
  assign VGA_HS      = hs_p2;
  assign VGA_VS      = vs_p2;
  assign VGA_BLANK_N = blank_p2;

endmodule

// File: tb/tb_maze_pixel_fetch.sv
// Randomised and directed bench for maze_pixel_fetch with a behavioural
// frame RAM and a per-pixel reference model of the expected outputs.
module tb_maze_pixel_fetch;

  localparam int X0 = 208;
  localparam int Y0 = 116;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        blank_n_in = 1'b0;
  logic [18:0] read_address;
  logic [4:0]  maze_data;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, frame_tick;
  logic [23:0] rgb;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [18:0] addr;
    logic [23:0] rgb;
  } rec_t;

  rec_t h0, h1, h2;
  logic prev_m;
  logic exp_tick;

  maze_pixel_fetch #(.MAZE_X0(X0), .MAZE_Y0(Y0)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .blank_n_in   (blank_n_in),
    .read_address (read_address),
    .maze_data    (maze_data),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .VGA_BLANK_N  (VGA_BLANK_N),
    .frame_tick   (frame_tick)
  );

  assign rgb = {VGA_R, VGA_G, VGA_B};

  always #5 Clk = ~Clk;

  function automatic logic [4:0] ram_word(input logic [18:0] a);
    return 5'((int'(a) * 3 + 1) % 6);
  endfunction

  function automatic logic [23:0] pal_ref(input logic [4:0] i);
    case (i)
      5'd1:       return 24'h2121DE;
      5'd2, 5'd3: return 24'hFFB8AE;
      5'd4:       return 24'hFFB8FF;
      default:    return 24'h000000;
    endcase
  endfunction

  // Synchronous-read frame RAM: data appears one clock after the address
  always @(posedge Clk) maze_data <= ram_word(read_address);

  function automatic rec_t idle_rec();
    rec_t r;
    r.hs = 1'b1; r.vs = 1'b1; r.bl = 1'b0; r.addr = '0; r.rgb = '0;
    return r;
  endfunction

  task automatic model_reset();
    h0 = idle_rec(); h1 = idle_rec(); h2 = idle_rec();
    prev_m = 1'b0;
    exp_tick = 1'b0;
  endtask

  // Drive one pixel, let one edge pass, update expectations, return at negedge
  task automatic step(input int x, input int y, input logic hs, input logic vs, input logic bl);
    rec_t r;
    bit   inreg;
    int   a;
    DrawX = 10'(x); DrawY = 10'(y);
    hs_in = hs; vs_in = vs; blank_n_in = bl;
    @(posedge Clk);
    inreg = (x >= X0) && (x < X0 + 224) && (y >= Y0) && (y < Y0 + 248);
    a = (inreg && bl) ? (y - Y0) * 224 + (x - X0) : 0;
    r.hs = hs; r.vs = vs; r.bl = bl;
    r.addr = 19'(a);
    r.rgb = (inreg && bl) ? pal_ref(ram_word(19'(a))) : 24'h000000;
    h2 = h1; h1 = h0; h0 = r;
    exp_tick = (x == 0 && y == 0) && !prev_m;
    prev_m = (x == 0 && y == 0);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    total++; if (read_address !== 19'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", read_address); end
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL reset_rgb got=%06h want=000000", rgb); end
    total++; if (VGA_HS !== 1'b1) begin bad++; $display("FAIL reset_hs got=%b want=1", VGA_HS); end
    total++; if (VGA_VS !== 1'b1) begin bad++; $display("FAIL reset_vs got=%b want=1", VGA_VS); end
    total++; if (VGA_BLANK_N !== 1'b0) begin bad++; $display("FAIL reset_blank got=%b want=0", VGA_BLANK_N); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
  endtask

  task automatic test_corner();
    step(208, 116, 1'b1, 1'b1, 1'b1);
    total++; if (read_address !== 19'd0) begin bad++; $display("FAIL corner_addr got=%0d want=0", read_address); end
    step(700, 10, 1'b1, 1'b1, 1'b1);
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL corner_early got=%06h want=000000", rgb); end
    step(700, 10, 1'b1, 1'b1, 1'b1);
    total++; if (rgb !== 24'h2121DE) begin bad++; $display("FAIL corner_rgb got=%06h want=2121de", rgb); end
  endtask

  task automatic test_last();
    step(431, 363, 1'b1, 1'b1, 1'b1);
    total++; if (read_address !== 19'd55551) begin bad++; $display("FAIL last_addr got=%0d want=55551", read_address); end
    step(432, 363, 1'b1, 1'b1, 1'b1);
    total++; if (read_address !== 19'd0) begin bad++; $display("FAIL past_addr got=%0d want=0", read_address); end
    step(500, 400, 1'b1, 1'b1, 1'b1);
    total++; if (rgb !== h2.rgb) begin bad++; $display("FAIL last_rgb got=%06h want=%06h", rgb, h2.rgb); end
    step(500, 400, 1'b1, 1'b1, 1'b1);
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL past_rgb got=%06h want=000000", rgb); end
  endtask

  task automatic test_sync_align();
    step(250, 200, 1'b1, 1'b1, 1'b1);
    step(251, 200, 1'b0, 1'b1, 1'b1);
    step(252, 200, 1'b1, 1'b1, 1'b1);
    total++; if (VGA_HS !== 1'b1) begin bad++; $display("FAIL hs_early got=%b want=1", VGA_HS); end
    step(253, 200, 1'b1, 1'b1, 1'b1);
    total++; if (VGA_HS !== 1'b0) begin bad++; $display("FAIL hs_toggle got=%b want=0", VGA_HS); end
    total++; if (rgb !== h2.rgb) begin bad++; $display("FAIL hs_pixel got=%06h want=%06h", rgb, h2.rgb); end
    for (int i = 0; i < 24; i++) begin
      step(260 + i, 201, logic'(i % 2), logic'((i / 3) % 2), 1'b1);
      total++;
      if ({VGA_HS, VGA_VS, rgb} !== {h2.hs, h2.vs, h2.rgb}) begin
        bad++;
        $display("FAIL sync_walk i=%0d got=%b%b/%06h want=%b%b/%06h", i, VGA_HS, VGA_VS, rgb, h2.hs, h2.vs, h2.rgb);
      end
    end
  endtask

  task automatic test_blank();
    step(300, 200, 1'b1, 1'b1, 1'b1);
    step(300, 200, 1'b1, 1'b1, 1'b1);
    step(301, 200, 1'b1, 1'b1, 1'b0);
    total++; if (read_address !== 19'd0) begin bad++; $display("FAIL blank_addr got=%0d want=0", read_address); end
    step(302, 200, 1'b1, 1'b1, 1'b1);
    total++; if (VGA_BLANK_N !== 1'b1) begin bad++; $display("FAIL blank_early got=%b want=1", VGA_BLANK_N); end
    step(303, 200, 1'b1, 1'b1, 1'b1);
    total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL blank_rgb got=%06h want=000000", rgb); end
    total++; if (VGA_BLANK_N !== 1'b0) begin bad++; $display("FAIL blank_flag got=%b want=0", VGA_BLANK_N); end
  endtask

  task automatic test_frame();
    int ticks = 0;
    int wide  = 0;
    logic last_tick = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 40; y++)
        for (int x = 0; x < 100; x++) begin
          step(x, y, logic'(x < 90), logic'(y > 1), logic'(x < 80 && y < 35));
          if (frame_tick === 1'b1) ticks++;
          if (frame_tick === 1'b1 && last_tick === 1'b1) wide++;
          last_tick = frame_tick;
        end
    total++; if (ticks !== 2) begin bad++; $display("FAIL frame_count got=%0d want=2", ticks); end
    total++; if (wide !== 0) begin bad++; $display("FAIL frame_width got=%0d want=0", wide); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1'b1, 1'b1, 1'b0);
      total++;
      if (frame_tick !== exp_tick) begin bad++; $display("FAIL tick_hold i=%0d got=%b want=%b", i, frame_tick, exp_tick); end
    end
  endtask

  task automatic test_random();
    int x, y;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
      end else if ($urandom_range(0, 19) == 0) begin
        x = 0; y = 0;
      end else begin
        x = $urandom_range(X0 - 3, X0 + 226); y = $urandom_range(Y0 - 3, Y0 + 250);
      end
      step(x, y, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 7) != 0));
      total++; if (read_address !== h0.addr) begin bad++; $display("FAIL rand_addr n=%0d got=%0d want=%0d", n, read_address, h0.addr); end
      total++; if (rgb !== h2.rgb) begin bad++; $display("FAIL rand_rgb n=%0d got=%06h want=%06h", n, rgb, h2.rgb); end
      total++;
      if ({VGA_HS, VGA_VS, VGA_BLANK_N} !== {h2.hs, h2.vs, h2.bl}) begin
        bad++; $display("FAIL rand_sync n=%0d got=%b%b%b want=%b%b%b", n, VGA_HS, VGA_VS, VGA_BLANK_N, h2.hs, h2.vs, h2.bl);
      end
      total++; if (frame_tick !== exp_tick) begin bad++; $display("FAIL rand_tick n=%0d got=%b want=%b", n, frame_tick, exp_tick); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(320 + i, 150, 1'b0, 1'b0, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if ({read_address, rgb, VGA_HS, VGA_VS, VGA_BLANK_N, frame_tick} !== {19'd0, 24'd0, 4'b1100}) begin
      bad++; $display("FAIL midreset_now got=%0d/%06h/%b%b%b%b want=0/000000/1100",
                      read_address, rgb, VGA_HS, VGA_VS, VGA_BLANK_N, frame_tick);
    end
    @(posedge Clk); @(negedge Clk);
    model_reset();
    total++; if (VGA_BLANK_N !== 1'b0 || rgb !== 24'h0) begin bad++; $display("FAIL midreset_hold got=%b/%06h want=0/000000", VGA_BLANK_N, rgb); end
    Reset_n = 1'b1;
    step(208, 116, 1'b0, 1'b0, 1'b1);
    total++; if ({VGA_BLANK_N, VGA_HS, rgb} !== {2'b01, 24'h0}) begin bad++; $display("FAIL release1 got=%b%b/%06h want=01/000000", VGA_BLANK_N, VGA_HS, rgb); end
    step(209, 116, 1'b0, 1'b0, 1'b1);
    total++; if ({VGA_BLANK_N, VGA_HS, rgb} !== {2'b01, 24'h0}) begin bad++; $display("FAIL release2 got=%b%b/%06h want=01/000000", VGA_BLANK_N, VGA_HS, rgb); end
    step(210, 116, 1'b0, 1'b0, 1'b1);
    total++; if ({VGA_BLANK_N, VGA_HS, rgb} !== {2'b10, 24'h2121DE}) begin bad++; $display("FAIL release3 got=%b%b/%06h want=10/2121de", VGA_BLANK_N, VGA_HS, rgb); end
  endtask

  initial begin
    model_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    test_reset();
    Reset_n = 1'b1;
    test_corner();
    test_last();
    test_sync_align();
    test_blank();
    test_frame();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
